// File: rtl/alu_pkg.sv
// Shared ALU op codes and the reservation-station entry layout.
// Entry field widths are fixed here; the station's TAG_W/DATA_W must match them.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    localparam int RS_TAG_W  = 6;
    localparam int RS_DATA_W = 32;

    typedef struct packed {
        logic                 rdy;
        logic [RS_TAG_W-1:0]  tag;
        logic [RS_DATA_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                valid;
        logic [3:0]          alu_ctrl;
        rs_src_t             src1;
        rs_src_t             src2;
        logic [RS_TAG_W-1:0] dst_tag;
    } rs_entry_t;

    // A waiting source captures the broadcast value when its producer tag matches.
    function automatic rs_src_t wake_src(input rs_src_t s, input logic hit_valid,
                                         input logic [RS_TAG_W-1:0] tag,
                                         input logic [RS_DATA_W-1:0] value);
        wake_src = s;
        if (hit_valid && !s.rdy && s.tag == tag) begin
            wake_src.rdy = 1'b1;
            wake_src.val = value;
        end
    endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index-first picker: one-hot grant of the first requesting slot.
module alu_rs_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any_ready
);

    always_comb begin
        grant     = '0;
        any_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !any_ready) begin
                grant[i]  = 1'b1;
                any_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing oldest-first queue with CDB wakeup and a registered issue stage.
// Optional macro ALU_RS_CDB_FWD_EN makes entries woken by the current CDB broadcast selectable at once.
module alu_reservation_station
    import alu_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = RS_TAG_W,
    parameter int DATA_W      = RS_DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic [3:0]                       disp_alu_ctrl,
    input  logic                             disp_src1_rdy,
    input  logic [TAG_W-1:0]                 disp_src1_tag,
    input  logic [DATA_W-1:0]                disp_src1_val,
    input  logic                             disp_src2_rdy,
    input  logic [TAG_W-1:0]                 disp_src2_tag,
    input  logic [DATA_W-1:0]                disp_src2_val,
    input  logic                             disp_use_imm,
    input  logic [DATA_W-1:0]                disp_imm,
    input  logic [TAG_W-1:0]                 disp_dst_tag,
    input  logic                             cdb_valid,
    input  logic [TAG_W-1:0]                 cdb_tag,
    input  logic [DATA_W-1:0]                cdb_value,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [DATA_W-1:0]                issue_a,
    output logic [DATA_W-1:0]                issue_b,
    output logic [3:0]                       issue_alu_ctrl,
    output logic [TAG_W-1:0]                 issue_dst_tag,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(NUM_ENTRIES+1);

    // Both ports: a transfer happens on a cycle where valid && ready at the rising edge;
    // the producer keeps its payload stable while valid is high and ready is low.

    rs_entry_t            q     [NUM_ENTRIES];
    rs_entry_t            woke  [NUM_ENTRIES];
    rs_entry_t            nxt   [NUM_ENTRIES];
    rs_entry_t            new_e;
    logic [NUM_ENTRIES-1:0] req, grant;
    logic                 any_rdy, load, accept, shift;
    logic [CNT_W-1:0]     occ, wr_idx;
    logic [DATA_W-1:0]    sel_a, sel_b;
    logic [3:0]           sel_ctrl;
    logic [TAG_W-1:0]     sel_dst;

    assign occupancy  = occ;
    assign disp_ready = !rst && (occ < CNT_W'(NUM_ENTRIES));
    assign accept     = disp_valid && disp_ready;
    assign load       = (!issue_valid || issue_ready) && any_rdy;
    assign wr_idx     = occ - CNT_W'(load);

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woke[i]      = q[i];
            woke[i].src1 = wake_src(q[i].src1, cdb_valid, cdb_tag, cdb_value);
            woke[i].src2 = wake_src(q[i].src2, cdb_valid, cdb_tag, cdb_value);
`ifdef ALU_RS_CDB_FWD_EN
            req[i] = woke[i].valid && woke[i].src1.rdy && woke[i].src2.rdy;
`else
            req[i] = q[i].valid && q[i].src1.rdy && q[i].src2.rdy;
`endif
        end
    end

    alu_rs_select #(.N(NUM_ENTRIES)) u_select (
        .req       (req),
        .grant     (grant),
        .any_ready (any_rdy)
    );

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        sel_dst  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) begin
`ifdef ALU_RS_CDB_FWD_EN
                sel_a = woke[i].src1.val;
                sel_b = woke[i].src2.val;
`else
                sel_a = q[i].src1.val;
                sel_b = q[i].src2.val;
`endif
                sel_ctrl = q[i].alu_ctrl;
                sel_dst  = q[i].dst_tag;
            end
        end
    end

    always_comb begin
        new_e          = '0;
        new_e.valid    = 1'b1;
        new_e.alu_ctrl = disp_alu_ctrl;
        new_e.dst_tag  = disp_dst_tag;
        new_e.src1.rdy = disp_src1_rdy;
        new_e.src1.tag = disp_src1_tag;
        new_e.src1.val = disp_src1_val;
        new_e.src1     = wake_src(new_e.src1, cdb_valid, cdb_tag, cdb_value);
        if (disp_use_imm) begin
            new_e.src2.rdy = 1'b1;
            new_e.src2.val = disp_imm;
        end else begin
            new_e.src2.rdy = disp_src2_rdy;
            new_e.src2.tag = disp_src2_tag;
            new_e.src2.val = disp_src2_val;
            new_e.src2     = wake_src(new_e.src2, cdb_valid, cdb_tag, cdb_value);
        end
    end

    // Collapse: every slot at or above the granted one takes its younger neighbour.
    always_comb begin
        shift = 1'b0;
        for (int i = 0; i < NUM_ENTRIES-1; i++) begin
            shift  = shift | (load && grant[i]);
            nxt[i] = shift ? woke[i+1] : woke[i];
        end
        shift = shift | (load && grant[NUM_ENTRIES-1]);
        nxt[NUM_ENTRIES-1] = shift ? rs_entry_t'('0) : woke[NUM_ENTRIES-1];
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (accept && wr_idx == CNT_W'(i)) nxt[i] = new_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) q[i] <= '0;
            occ            <= '0;
            issue_valid    <= 1'b0;
            issue_a        <= '0;
            issue_b        <= '0;
            issue_alu_ctrl <= '0;
            issue_dst_tag  <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) q[i].valid <= 1'b0;
            occ         <= '0;
            issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) q[i] <= nxt[i];
            occ <= occ + CNT_W'(accept) - CNT_W'(load);
            if (load) begin
                issue_valid    <= 1'b1;
                issue_a        <= sel_a;
                issue_b        <= sel_b;
                issue_alu_ctrl <= sel_ctrl;
                issue_dst_tag  <= sel_dst;
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus a randomized run against a queue model.
module tb_alu_reservation_station;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
`ifdef ALU_RS_CDB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk, rst, flush;
    logic          disp_valid, disp_ready;
    logic [3:0]    disp_alu_ctrl;
    logic          disp_src1_rdy, disp_src2_rdy, disp_use_imm;
    logic [TW-1:0] disp_src1_tag, disp_src2_tag, disp_dst_tag, cdb_tag, issue_dst_tag;
    logic [DW-1:0] disp_src1_val, disp_src2_val, disp_imm, cdb_value, issue_a, issue_b;
    logic          cdb_valid, issue_valid, issue_ready;
    logic [3:0]    issue_alu_ctrl;
    logic [2:0]    occupancy;

    int checks   = 0;
    int failures = 0;

    alu_reservation_station #(.NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_ctrl(disp_alu_ctrl),
        .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
        .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
        .disp_use_imm(disp_use_imm), .disp_imm(disp_imm), .disp_dst_tag(disp_dst_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_a(issue_a), .issue_b(issue_b),
        .issue_alu_ctrl(issue_alu_ctrl), .issue_dst_tag(issue_dst_tag), .occupancy(occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; disp_valid = 0; disp_alu_ctrl = 0;
        disp_src1_rdy = 0; disp_src1_tag = 0; disp_src1_val = 0;
        disp_src2_rdy = 0; disp_src2_tag = 0; disp_src2_val = 0;
        disp_use_imm = 0; disp_imm = 0; disp_dst_tag = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0; issue_ready = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    // driver tasks
    task automatic set_disp(input logic [3:0] ctrl, input logic r1, input logic [TW-1:0] t1,
                            input logic [DW-1:0] v1, input logic r2, input logic [TW-1:0] t2,
                            input logic [DW-1:0] v2, input logic ui, input logic [DW-1:0] imm,
                            input logic [TW-1:0] dst);
        disp_valid = 1; disp_alu_ctrl = ctrl;
        disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
        disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
        disp_use_imm = ui; disp_imm = imm; disp_dst_tag = dst;
    endtask

    task automatic set_cdb(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        cdb_valid = v; cdb_tag = t; cdb_value = d;
    endtask

    // reference model: an ordered list of waiting ops and the issue register
    typedef struct {
        logic [3:0]    ctrl;
        bit            r1, r2;
        logic [TW-1:0] t1, t2, dst;
        logic [DW-1:0] v1, v2;
    } m_ent_t;

    m_ent_t        m_q[$];
    bit            m_iv;
    logic [DW-1:0] m_a, m_b;
    logic [3:0]    m_ctrl;
    logic [TW-1:0] m_dst;

    function automatic bit src_ok(bit r, logic [TW-1:0] t);
        return r || (FWD && cdb_valid && cdb_tag == t);
    endfunction

    function automatic logic [DW-1:0] src_v(bit r, logic [TW-1:0] t, logic [DW-1:0] v);
        return r ? v : cdb_value;
    endfunction

    task automatic model_step();
        int sel;
        bit take;
        m_ent_t e;
        sel  = -1;
        take = disp_valid && (m_q.size() < N);
        foreach (m_q[i]) if (sel < 0 && src_ok(m_q[i].r1, m_q[i].t1) && src_ok(m_q[i].r2, m_q[i].t2)) sel = i;
        if (flush) begin
            m_q.delete();
            m_iv = 0;
            return;
        end
        if ((!m_iv || issue_ready) && sel >= 0) begin
            m_iv   = 1;
            m_a    = src_v(m_q[sel].r1, m_q[sel].t1, m_q[sel].v1);
            m_b    = src_v(m_q[sel].r2, m_q[sel].t2, m_q[sel].v2);
            m_ctrl = m_q[sel].ctrl;
            m_dst  = m_q[sel].dst;
            m_q.delete(sel);
        end else if (issue_ready) begin
            m_iv = 0;
        end
        if (take) begin
            e.ctrl = disp_alu_ctrl; e.dst = disp_dst_tag;
            e.r1 = disp_src1_rdy; e.t1 = disp_src1_tag; e.v1 = disp_src1_val;
            if (disp_use_imm) begin
                e.r2 = 1; e.t2 = 0; e.v2 = disp_imm;
            end else begin
                e.r2 = disp_src2_rdy; e.t2 = disp_src2_tag; e.v2 = disp_src2_val;
            end
            m_q.push_back(e);
        end
        // every op still waiting (including the one just dispatched) hears the broadcast
        foreach (m_q[i]) begin
            if (cdb_valid && !m_q[i].r1 && m_q[i].t1 == cdb_tag) begin m_q[i].r1 = 1; m_q[i].v1 = cdb_value; end
            if (cdb_valid && !m_q[i].r2 && m_q[i].t2 == cdb_tag) begin m_q[i].r2 = 1; m_q[i].v2 = cdb_value; end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #1;
        checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL reset_disp_ready got=%0b want=0", disp_ready); end
        step();
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_iv got=%0b want=0", issue_valid); end
        checks++; if ({issue_a, issue_b, issue_alu_ctrl, issue_dst_tag} !== '0) begin failures++;
            $display("FAIL reset_payload got a=%0h b=%0h c=%0h d=%0h want all 0", issue_a, issue_b, issue_alu_ctrl, issue_dst_tag); end
        rst = 0;
        #1;
        checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL post_reset_disp_ready got=%0b want=1", disp_ready); end
    endtask

    task automatic test_basic_issue();
        reset_dut();
        issue_ready = 1;
        set_disp(ALU_ADD, 1, 0, 5, 1, 0, 7, 0, 0, 3);
        step();
        disp_valid = 0;
        checks++; if (occupancy !== 3'd1 || issue_valid !== 1'b0) begin failures++;
            $display("FAIL basic_t1 got occ=%0d iv=%0b want occ=1 iv=0", occupancy, issue_valid); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_a !== 32'd5 || issue_b !== 32'd7 ||
                      issue_alu_ctrl !== ALU_ADD || issue_dst_tag !== 6'd3) begin failures++;
            $display("FAIL basic_issue got iv=%0b a=%0d b=%0d c=%0b d=%0d want 1 5 7 0010 3",
                     issue_valid, issue_a, issue_b, issue_alu_ctrl, issue_dst_tag); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL basic_occ got=%0d want=0", occupancy); end
        step();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got iv=%0b want=0", issue_valid); end
    endtask

    task automatic test_cdb_wakeup();
        reset_dut();
        issue_ready = 1;
        set_disp(ALU_SUB, 0, 9, 0, 1, 0, 1, 0, 0, 5);
        step();
        disp_valid = 0;
        step();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_wait got iv=%0b want=0", issue_valid); end
        set_cdb(1, 9, 100);
        step();
        set_cdb(0, 0, 0);
        checks++; if (issue_valid !== FWD) begin failures++; $display("FAIL wake_edge got iv=%0b want=%0b", issue_valid, FWD); end
        if (!FWD) step();
        checks++; if (issue_valid !== 1'b1 || issue_a !== 32'd100 || issue_b !== 32'd1 || issue_alu_ctrl !== ALU_SUB) begin
            failures++; $display("FAIL wake_issue got iv=%0b a=%0d b=%0d c=%0b want 1 100 1 0110",
                                 issue_valid, issue_a, issue_b, issue_alu_ctrl); end
    endtask

    task automatic test_full_backpressure();
        reset_dut();
        issue_ready = 0;
        for (int k = 0; k < 5; k++) begin
            set_disp(ALU_ADD, 1, 0, 10 + k, 1, 0, 20 + k, 0, 0, TW'(k));
            step();
        end
        disp_valid = 0;
        checks++; if (occupancy !== 3'd4 || disp_ready !== 1'b0) begin failures++;
            $display("FAIL full_occ got occ=%0d rdy=%0b want 4 0", occupancy, disp_ready); end
        set_disp(ALU_XOR, 1, 0, 99, 1, 0, 99, 0, 0, 9);
        step();
        disp_valid = 0;
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_drop got occ=%0d want=4", occupancy); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_a !== 32'd10 || issue_dst_tag !== 6'd0) begin failures++;
            $display("FAIL full_hold got iv=%0b a=%0d d=%0d want 1 10 0", issue_valid, issue_a, issue_dst_tag); end
        issue_ready = 1;
        for (int k = 1; k < 5; k++) begin
            step();
            checks++; if (issue_valid !== 1'b1 || issue_a !== DW'(10 + k) || issue_b !== DW'(20 + k) ||
                          occupancy !== 3'(4 - k)) begin failures++;
                $display("FAIL full_drain%0d got iv=%0b a=%0d b=%0d occ=%0d want 1 %0d %0d %0d",
                         k, issue_valid, issue_a, issue_b, occupancy, 10 + k, 20 + k, 4 - k); end
        end
        step();
        checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin failures++;
            $display("FAIL full_empty got iv=%0b occ=%0d want 0 0", issue_valid, occupancy); end
    endtask

    task automatic test_out_of_order();
        reset_dut();
        issue_ready = 1;
        set_disp(ALU_ADD, 0, 12, 0, 1, 0, 2, 0, 0, 1);
        step();
        set_disp(ALU_OR, 1, 0, 3, 1, 0, 4, 0, 0, 2);
        step();
        disp_valid = 0;
        step();
        checks++; if (issue_valid !== 1'b1 || issue_dst_tag !== 6'd2 || issue_a !== 32'd3 || issue_alu_ctrl !== ALU_OR) begin
            failures++; $display("FAIL ooo_first got iv=%0b d=%0d a=%0d want 1 2 3", issue_valid, issue_dst_tag, issue_a); end
        set_cdb(1, 12, 50);
        step();
        set_cdb(0, 0, 0);
        checks++; if (issue_valid !== FWD) begin failures++; $display("FAIL ooo_gap got iv=%0b want=%0b", issue_valid, FWD); end
        if (!FWD) step();
        checks++; if (issue_valid !== 1'b1 || issue_dst_tag !== 6'd1 || issue_a !== 32'd50 || issue_b !== 32'd2) begin
            failures++; $display("FAIL ooo_second got iv=%0b d=%0d a=%0d b=%0d want 1 1 50 2",
                                 issue_valid, issue_dst_tag, issue_a, issue_b); end
    endtask

    task automatic test_bypass_imm();
        reset_dut();
        issue_ready = 1;
        set_disp(ALU_SRA, 0, 4, 0, 0, 7, 32'hdead, 1, 4, 8);
        set_cdb(1, 4, 32'h8000_0000);
        step();
        disp_valid = 0;
        set_cdb(0, 0, 0);
        step();
        checks++; if (issue_valid !== 1'b1 || issue_a !== 32'h8000_0000 || issue_b !== 32'd4 || issue_alu_ctrl !== ALU_SRA) begin
            failures++; $display("FAIL bypass_imm got iv=%0b a=%0h b=%0h c=%0b want 1 80000000 4 0111",
                                 issue_valid, issue_a, issue_b, issue_alu_ctrl); end
    endtask

    task automatic test_flush();
        reset_dut();
        issue_ready = 0;
        for (int k = 0; k < 4; k++) begin
            set_disp(ALU_ADD, 1, 0, k, 1, 0, k, 0, 0, TW'(k));
            step();
        end
        checks++; if (occupancy !== 3'd3 || issue_valid !== 1'b1) begin failures++;
            $display("FAIL flush_pre got occ=%0d iv=%0b want 3 1", occupancy, issue_valid); end
        set_disp(ALU_ADD, 1, 0, 1, 1, 0, 1, 0, 0, 7);
        flush = 1;
        step();
        flush = 0;
        disp_valid = 0;
        checks++; if (occupancy !== 3'd0 || issue_valid !== 1'b0) begin failures++;
            $display("FAIL flush_edge got occ=%0d iv=%0b want 0 0", occupancy, issue_valid); end
        issue_ready = 1;
        step();
        checks++; if (occupancy !== 3'd0 || issue_valid !== 1'b0 || disp_ready !== 1'b1) begin failures++;
            $display("FAIL flush_after got occ=%0d iv=%0b rdy=%0b want 0 0 1", occupancy, issue_valid, disp_ready); end
    endtask

    task automatic test_random();
        reset_dut();
        m_q.delete();
        m_iv = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            flush         = ($urandom_range(0, 99) < 3);
            disp_valid    = ($urandom_range(0, 99) < 60);
            disp_alu_ctrl = 4'($urandom);
            disp_src1_rdy = $urandom_range(0, 1);
            disp_src1_tag = TW'($urandom_range(0, 7));
            disp_src1_val = $urandom;
            disp_src2_rdy = $urandom_range(0, 1);
            disp_src2_tag = TW'($urandom_range(0, 7));
            disp_src2_val = $urandom;
            disp_use_imm  = ($urandom_range(0, 99) < 25);
            disp_imm      = $urandom;
            disp_dst_tag  = TW'($urandom);
            cdb_valid     = ($urandom_range(0, 99) < 45);
            cdb_tag       = TW'($urandom_range(0, 7));
            cdb_value     = $urandom;
            issue_ready   = ($urandom_range(0, 99) < 70);
            model_step();
            step();
            checks++; if (issue_valid !== m_iv || occupancy !== 3'(m_q.size()) || disp_ready !== (m_q.size() < N)) begin
                failures++; $display("FAIL rand_ctl cyc=%0d got iv=%0b occ=%0d rdy=%0b want %0b %0d %0b",
                                     cyc, issue_valid, occupancy, disp_ready, m_iv, m_q.size(), m_q.size() < N); end
            if (m_iv) begin
                checks++; if (issue_a !== m_a || issue_b !== m_b || issue_alu_ctrl !== m_ctrl || issue_dst_tag !== m_dst) begin
                    failures++; $display("FAIL rand_payload cyc=%0d got a=%0h b=%0h c=%0h d=%0h want %0h %0h %0h %0h",
                                         cyc, issue_a, issue_b, issue_alu_ctrl, issue_dst_tag, m_a, m_b, m_ctrl, m_dst); end
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic_issue();
        test_cdb_wakeup();
        test_full_backpressure();
        test_out_of_order();
        test_bypass_imm();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side producer for the integer ALU. Drives its A, B and ALUControl operands.
- Buffers dispatched ALU micro-ops until both source operands are available. Wakes them up from the common data bus (CDB).
- Issues the oldest ready micro-op to the ALU through a valid/ready handshake.
- Sits between rename/dispatch and the ALU execute stage in the out-of-order core.

Parameters:
- NUM_ENTRIES, 4, number of buffered micro-ops (≥2).
- TAG_W, 6, physical-register tag width.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash all buffered and pending-issue micro-ops
- disp_valid  in  1  dispatch request
- disp_ready  out  1  an entry is free
- disp_alu_ctrl  in  4  ALU op code
- disp_src1_rdy  in  1  src1 value valid
- disp_src1_tag  in  TAG_W  src1 producer tag
- disp_src1_val  in  DATA_W  src1 value
- disp_src2_rdy  in  1  src2 value valid
- disp_src2_tag  in  TAG_W  src2 producer tag
- disp_src2_val  in  DATA_W  src2 value
- disp_use_imm  in  1  operand B is the immediate
- disp_imm  in  DATA_W  immediate
- disp_dst_tag  in  TAG_W  destination tag
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  DATA_W  broadcast value
- issue_valid  out  1  issue payload valid
- issue_ready  in  1  ALU stage accepts
- issue_a  out  DATA_W  ALU operand A
- issue_b  out  DATA_W  ALU operand B
- issue_alu_ctrl  out  4  ALUControl
- issue_dst_tag  out  TAG_W  destination tag of the issued op
- occupancy  out  $clog2(NUM_ENTRIES+1)  valid entry count

Behaviour:
- Reset and flush:
  - rst high: all entries invalid, occupancy=0, issue_valid=0, issue_a/b/alu_ctrl/dst_tag=0, disp_ready=0.
  - disp_ready=1 from the first cycle after rst deasserts.
- Storage:
  - Collapsing queue; slot 0 is the oldest entry.
  - Removing an entry shifts all younger entries down one slot in the same edge.
  - A new entry is written to the first free slot after the collapse.
- Dispatch:
  - Accepted when disp_valid && disp_ready.
  - disp_ready = (occupancy < NUM_ENTRIES), computed from the registered count. A slot freed in the same cycle does not raise disp_ready.
  - disp_use_imm=1: src2 is stored ready with value disp_imm; disp_src2_* are ignored.
- Wakeup:
  - Every valid entry with an unready source whose tag equals cdb_tag while cdb_valid=1 captures cdb_value and marks that source ready at the edge.
  - Applies to an entry being dispatched in the same cycle (dispatch/CDB bypass).
  - One CDB match can wake both sources of one entry.
- Select: the lowest-index entry with both sources ready.
- Issue register:
  - Loads when (!issue_valid || issue_ready) and a ready entry exists. The selected entry is removed at the same edge.
  - issue_valid && !issue_ready: payload held stable, no load.
  - Handshake with no ready entry: issue_valid=0 next cycle.
- Latency:
  - Both sources ready at dispatch edge t: issue_valid high after edge t+1, so visible in cycle t+2.
  - CDB wakeup at edge t: eligible for selection in cycle t+1.
- ALU op codes: disp_alu_ctrl passes to issue_alu_ctrl unchanged; unknown codes are passed through unchanged.
- Width rules: occupancy never exceeds NUM_ENTRIES; no arithmetic on operands.
- Flush:
  - Synchronous. Clears all entries and issue_valid at the edge.
  - Has priority over a same-cycle dispatch, issue load and wakeup.
- Priority of rst over flush: rst > flush.

Optional Feature:
- ALU_RS_CDB_FWD_EN defined:
  - An entry whose only missing source(s) match the current CDB broadcast is selectable in the same cycle.
  - cdb_value is forwarded directly into issue_a/issue_b. Saves one cycle of wakeup-to-issue.
  - Oldest-first order still holds among all selectable entries.
- Undefined: wakeup takes effect only from the following cycle.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_OR=4'b0001, ALU_XOR=4'b0011, ALU_SRA=4'b0111.
  - rs_entry_t struct: valid, alu_ctrl, src1/src2 {rdy, tag, val}, dst_tag.
- Sub-module alu_rs_select: combinational lowest-index-ready priority picker. Outputs a one-hot grant and an any-ready flag.

Test Plan:
1. Dispatch ADD src1=5, src2=7, both ready, dst=3, issue_ready=1 -> cycle t+2: issue_valid=1, a=5, b=7, ctrl=0010, dst_tag=3; occupancy returns to 0.
2. Dispatch SUB, src1 unready tag 9, src2=1; CDB tag 9 value 100 two cycles later -> issue a=100, b=1, ctrl=0110 one cycle after the broadcast (same cycle with ALU_RS_CDB_FWD_EN).
3. Fill 4 entries with issue_ready=0 -> occupancy=4, disp_ready=0; a 5th disp_valid is dropped; issue payload is held stable until issue_ready=1.
4. Slot0 waiting on tag 12, slot1 ready -> slot1 issues first; after CDB tag 12 the former slot0 issues next.
5. Dispatch SRA with src1 unready tag 4, disp_use_imm=1, imm=4, and a same-cycle CDB broadcast of tag 4 value 0x80000000 -> issue a=0x80000000, b=4, ctrl=0111.
6. Three entries valid and issue_valid=1, assert flush with a simultaneous dispatch -> next cycle occupancy=0, issue_valid=0, dispatch discarded.
